// File: rtl/idma_legalizer_rw_axi_q.sv
// idma_legalizer_rw_axi_q
// Splits queued 1D transfers into AXI INCR read and write bursts. A burst never
// crosses a bound of min(PageSize, MaxBeats*StrbWidth) bytes. A small request
// FIFO (with a bypass when empty) lets the next transfer start without a bubble.
// Each transfer runs either coupled, where both channels split identically and
// advance together, or decoupled, where each channel splits and advances on
// its own.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_*                    transfer request (src, dst, length, decouple) with valid/ready
//   r_* / w_*                read / write burst: aligned addr, len, offset, tailer, last,
//                            valid/ready
//   kill_i                   abort the active transfer (the FIFO is kept)
//   busy_o                   FIFO holds a request or a transfer is active
//   r_bursts_o, w_bursts_o   accepted burst counters  (IDMA_LEGALIZER_QSTATS_EN only)
//   req_drop_o               pulse per killed active transfer (IDMA_LEGALIZER_QSTATS_EN only)
//
// Optional feature macro: IDMA_LEGALIZER_QSTATS_EN
module idma_legalizer_rw_axi_q #(
   parameter  int unsigned DataWidth = 32,
   parameter  int unsigned AddrWidth = 32,
   parameter  int unsigned LenWidth  = 32,
   parameter  int unsigned MaxBeats  = 256,
   parameter  int unsigned PageSize  = 4096,
   parameter  int unsigned ReqDepth  = 2,
   localparam int unsigned OffW      = $clog2(DataWidth / 8)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] req_src_addr_i,
   input  logic [AddrWidth-1:0] req_dst_addr_i,
   input  logic [LenWidth-1:0]  req_length_i,
   input  logic                 req_decouple_rw_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   output logic [AddrWidth-1:0] r_addr_o,
   output logic [7:0]           r_len_o,
   output logic [OffW-1:0]      r_offset_o,
   output logic [OffW-1:0]      r_tailer_o,
   output logic                 r_last_o,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [AddrWidth-1:0] w_addr_o,
   output logic [7:0]           w_len_o,
   output logic [OffW-1:0]      w_offset_o,
   output logic [OffW-1:0]      w_tailer_o,
   output logic                 w_last_o,
   output logic                 w_valid_o,
   input  logic                 w_ready_i,
   input  logic                 kill_i,
`ifdef IDMA_LEGALIZER_QSTATS_EN
   output logic [31:0]          r_bursts_o,
   output logic [31:0]          w_bursts_o,
   output logic                 req_drop_o,
`endif
   output logic                 busy_o
);

   localparam int unsigned StrbWidth  = DataWidth / 8;
   localparam int unsigned BurstBytes = MaxBeats * StrbWidth;
   localparam int unsigned Bound      = (PageSize < BurstBytes) ? PageSize : BurstBytes;
   localparam int unsigned BoundW     = $clog2(Bound);
   localparam int unsigned NW         = BoundW + 1;
   localparam int unsigned CmpW       = (LenWidth > NW) ? LenWidth : NW;
   localparam int unsigned SumW       = NW + 2;
   localparam int unsigned BeatW      = SumW - OffW;
   localparam int unsigned PtrW       = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
   localparam int unsigned CntW       = $clog2(ReqDepth + 1);

   // Chunk size: min(remaining bytes, bytes to the next bound)
   function automatic logic [NW-1:0] clamp_len(input logic [LenWidth-1:0] rem,
                                               input logic [NW-1:0]       lim);
      return (CmpW'(rem) < CmpW'(lim)) ? NW'(rem) : lim;
   endfunction

   // AXI len (beats-1); a zero-byte chunk is still issued as a single beat
   function automatic logic [7:0] beats_m1(input logic [OffW-1:0] off,
                                           input logic [NW-1:0]   n);
      logic [SumW-1:0]  sum;
      logic [BeatW-1:0] beats;
      sum   = SumW'(off) + SumW'(n) + SumW'(StrbWidth - 1);
      beats = sum[SumW-1:OffW];
      if (n == '0) return 8'd0;
      return 8'(beats - BeatW'(1));
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(ReqDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // ---------------------------------------------------------------- request FIFO
   logic [AddrWidth-1:0] q_src [ReqDepth];
   logic [AddrWidth-1:0] q_dst [ReqDepth];
   logic [LenWidth-1:0]  q_len [ReqDepth];
   logic                 q_dec [ReqDepth];
   logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]      count_q;

   logic                 fifo_empty, push, pop, wr_en, head_valid, load;
   logic [AddrWidth-1:0] head_src, head_dst;
   logic [LenWidth-1:0]  head_len;
   logic                 head_dec;

   assign fifo_empty  = (count_q == '0);
   assign req_ready_o = (count_q != CntW'(ReqDepth));
   assign push        = req_valid_i & req_ready_o;
   // An empty FIFO hands the incoming request straight to the machines
   assign head_valid  = !fifo_empty | push;
   assign head_src    = fifo_empty ? req_src_addr_i    : q_src[rd_ptr_q];
   assign head_dst    = fifo_empty ? req_dst_addr_i    : q_dst[rd_ptr_q];
   assign head_len    = fifo_empty ? req_length_i      : q_len[rd_ptr_q];
   assign head_dec    = fifo_empty ? req_decouple_rw_i : q_dec[rd_ptr_q];
   assign pop         = load & !fifo_empty;
   assign wr_en       = push & !(load & fifo_empty);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(ReqDepth); i++) begin
            q_src[i] <= '0;
            q_dst[i] <= '0;
            q_len[i] <= '0;
            q_dec[i] <= 1'b0;
         end
      end else begin
         if (wr_en) begin
            q_src[wr_ptr_q] <= req_src_addr_i;
            q_dst[wr_ptr_q] <= req_dst_addr_i;
            q_len[wr_ptr_q] <= req_length_i;
            q_dec[wr_ptr_q] <= req_decouple_rw_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CntW'(wr_en) - CntW'(pop);
      end
   end

   // ---------------------------------------------------------------- split machines
   logic                 r_active_q, r_active_d, w_active_q, w_active_d, dec_q, dec_d;
   logic [AddrWidth-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
   logic [LenWidth-1:0]  r_rem_q, r_rem_d, w_rem_q, w_rem_d;

   logic [NW-1:0]   r_tob, w_tob, r_n_own, w_n_own, n_cpl, r_n, w_n;
   logic [OffW-1:0] r_off, w_off;
   logic            r_last, w_last, r_fire, w_fire, r_end, w_end, r_done, w_done;

   assign r_tob   = NW'(Bound) - NW'(r_addr_q[BoundW-1:0]);
   assign w_tob   = NW'(Bound) - NW'(w_addr_q[BoundW-1:0]);
   assign r_n_own = clamp_len(r_rem_q, r_tob);
   assign w_n_own = clamp_len(w_rem_q, w_tob);
   // Coupled: both channels share rem, so the common chunk is the smaller own chunk
   assign n_cpl   = (r_n_own < w_n_own) ? r_n_own : w_n_own;
   assign r_n     = dec_q ? r_n_own : n_cpl;
   assign w_n     = dec_q ? w_n_own : n_cpl;
   assign r_off   = r_addr_q[OffW-1:0];
   assign w_off   = w_addr_q[OffW-1:0];
   assign r_last  = (CmpW'(r_rem_q) == CmpW'(r_n));
   assign w_last  = (CmpW'(w_rem_q) == CmpW'(w_n));

   assign r_fire  = r_active_q & r_ready_i & (dec_q | w_ready_i);
   assign w_fire  = w_active_q & w_ready_i & (dec_q | r_ready_i);
   assign r_end   = !r_active_q | (r_fire & r_last);
   assign w_end   = !w_active_q | (w_fire & w_last);
   assign r_done  = r_end | kill_i;
   assign w_done  = w_end | kill_i;
   assign load    = head_valid & r_done & w_done;

   assign r_addr_o   = {r_addr_q[AddrWidth-1:OffW], OffW'(0)};
   assign r_len_o    = beats_m1(r_off, r_n);
   assign r_offset_o = r_off;
   assign r_tailer_o = r_off + r_n[OffW-1:0];
   assign r_last_o   = r_active_q & r_last;
   assign r_valid_o  = r_active_q;
   assign w_addr_o   = {w_addr_q[AddrWidth-1:OffW], OffW'(0)};
   assign w_len_o    = beats_m1(w_off, w_n);
   assign w_offset_o = w_off;
   assign w_tailer_o = w_off + w_n[OffW-1:0];
   assign w_last_o   = w_active_q & w_last;
   assign w_valid_o  = w_active_q;
   assign busy_o     = !fifo_empty | r_active_q | w_active_q;

   // Next state: load a new transfer, else advance on handshake; kill idles both
   always_comb begin
      r_active_d = r_active_q;
      w_active_d = w_active_q;
      dec_d      = dec_q;
      r_addr_d   = r_addr_q;
      w_addr_d   = w_addr_q;
      r_rem_d    = r_rem_q;
      w_rem_d    = w_rem_q;
      if (load) begin
         r_active_d = 1'b1;
         w_active_d = 1'b1;
         dec_d      = head_dec;
         r_addr_d   = head_src;
         w_addr_d   = head_dst;
         r_rem_d    = head_len;
         w_rem_d    = head_len;
      end else begin
         if (r_fire) begin
            r_addr_d = r_addr_q + AddrWidth'(r_n);
            r_rem_d  = r_rem_q - LenWidth'(r_n);
            if (r_last) r_active_d = 1'b0;
         end
         if (w_fire) begin
            w_addr_d = w_addr_q + AddrWidth'(w_n);
            w_rem_d  = w_rem_q - LenWidth'(w_n);
            if (w_last) w_active_d = 1'b0;
         end
         if (kill_i) begin
            r_active_d = 1'b0;
            w_active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_active_q <= 1'b0;
         w_active_q <= 1'b0;
         dec_q      <= 1'b0;
         r_addr_q   <= '0;
         w_addr_q   <= '0;
         r_rem_q    <= '0;
         w_rem_q    <= '0;
      end else begin
         r_active_q <= r_active_d;
         w_active_q <= w_active_d;
         dec_q      <= dec_d;
         r_addr_q   <= r_addr_d;
         w_addr_q   <= w_addr_d;
         r_rem_q    <= r_rem_d;
         w_rem_q    <= w_rem_d;
      end
   end

   // ---------------------------------------------------------------- statistics
`ifdef IDMA_LEGALIZER_QSTATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bursts_o <= '0;
         w_bursts_o <= '0;
         req_drop_o <= 1'b0;
      end else begin
         r_bursts_o <= r_bursts_o + 32'(r_fire);
         w_bursts_o <= w_bursts_o + 32'(w_fire);
         // A kill only drops something if the transfer would not end this cycle anyway
         req_drop_o <= kill_i & !(r_end & w_end);
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_idma_legalizer_rw_axi_q.sv
// Scoreboard bench for idma_legalizer_rw_axi_q (DataWidth=32, MaxBeats=4,
// PageSize=4096 -> 16-byte bound). A transaction-level model computes every
// expected burst when a request is accepted; a negedge monitor pops and
// compares on each handshake.
module tb_idma_legalizer_rw_axi_q;

   localparam int unsigned BOUND = 16;
   localparam int unsigned STRB  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] req_src, req_dst, req_len;
   logic        req_dec, req_valid, req_ready;
   logic [31:0] r_addr, w_addr;
   logic [7:0]  r_len, w_len;
   logic [1:0]  r_off, r_tail, w_off, w_tail;
   logic        r_last, r_valid, r_ready, w_last, w_valid, w_ready;
   logic        kill, busy;

   always #5 clk = ~clk;

   idma_legalizer_rw_axi_q #(
      .DataWidth(32), .AddrWidth(32), .LenWidth(32),
      .MaxBeats(4), .PageSize(4096), .ReqDepth(2)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_src_addr_i(req_src), .req_dst_addr_i(req_dst), .req_length_i(req_len),
      .req_decouple_rw_i(req_dec), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .r_addr_o(r_addr), .r_len_o(r_len), .r_offset_o(r_off), .r_tailer_o(r_tail),
      .r_last_o(r_last), .r_valid_o(r_valid), .r_ready_i(r_ready),
      .w_addr_o(w_addr), .w_len_o(w_len), .w_offset_o(w_off), .w_tailer_o(w_tail),
      .w_last_o(w_last), .w_valid_o(w_valid), .w_ready_i(w_ready),
      .kill_i(kill), .busy_o(busy)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  off;
      logic [1:0]  tail;
      bit          last;
      bit          coupled;
      int          id;
   } burst_t;

   burst_t rq[$];
   burst_t wq[$];
   int     errors = 0;
   int     checks = 0;
   int     next_id = 0;
   bit     rand_done;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic [31:0] a, input logic [7:0] l,
                                        input logic [1:0] o, input logic [1:0] t, input logic la);
      return {19'b0, a, l, o, t, la};
   endfunction

   // One expected burst from plain arithmetic on byte counts
   function automatic burst_t mk(input logic [31:0] a, input int unsigned n,
                                 input int unsigned rem, input bit cpl, input int id);
      burst_t      b;
      int unsigned off;
      off       = a % STRB;
      b.addr    = a - off;
      b.off     = 2'(off);
      b.tail    = 2'((off + n) % STRB);
      b.len     = (n == 0) ? 8'd0 : 8'((off + n + STRB - 1) / STRB - 1);
      b.last    = (rem == n);
      b.coupled = cpl;
      b.id      = id;
      return b;
   endfunction

   function automatic int unsigned umin(input int unsigned x, input int unsigned y);
      return (x < y) ? x : y;
   endfunction

   function automatic void model(input logic [31:0] s, input logic [31:0] d,
                                 input logic [31:0] l, input bit dec, input int id);
      int unsigned rem, n;
      logic [31:0] a;
      logic [31:0] b;
      if (!dec) begin
         rem = l; a = s; b = d;
         do begin
            n = umin(rem, umin(BOUND - (a % BOUND), BOUND - (b % BOUND)));
            rq.push_back(mk(a, n, rem, 1'b1, id));
            wq.push_back(mk(b, n, rem, 1'b1, id));
            a = a + n; b = b + n; rem = rem - n;
         end while (rem != 0);
      end else begin
         rem = l; a = s;
         do begin
            n = umin(rem, BOUND - (a % BOUND));
            rq.push_back(mk(a, n, rem, 1'b0, id));
            a = a + n; rem = rem - n;
         end while (rem != 0);
         rem = l; b = d;
         do begin
            n = umin(rem, BOUND - (b % BOUND));
            wq.push_back(mk(b, n, rem, 1'b0, id));
            b = b + n; rem = rem - n;
         end while (rem != 0);
      end
   endfunction

   // Monitor: handshakes are decided by values stable at the falling edge
   always @(negedge clk) begin : mon
      burst_t e;
      if (rst_n) begin
         if (r_valid && rq.size() == 0)
            chk("r_unexpected_burst", {63'b0, r_valid}, 64'd0);
         else if (r_valid && r_ready && (!rq[0].coupled || w_ready)) begin
            e = rq.pop_front();
            chk($sformatf("r_burst_id%0d", e.id), pack(r_addr, r_len, r_off, r_tail, r_last),
                pack(e.addr, e.len, e.off, e.tail, e.last));
         end
         if (w_valid && wq.size() == 0)
            chk("w_unexpected_burst", {63'b0, w_valid}, 64'd0);
         else if (w_valid && w_ready && (!wq[0].coupled || r_ready)) begin
            e = wq.pop_front();
            chk($sformatf("w_burst_id%0d", e.id), pack(w_addr, w_len, w_off, w_tail, w_last),
                pack(e.addr, e.len, e.off, e.tail, e.last));
         end
      end
   end

   task automatic push(input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] l, input bit dec);
      int k;
      @(negedge clk);
      req_src = s; req_dst = d; req_len = l; req_dec = dec; req_valid = 1'b1;
      k = 0;
      while (!req_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         chk("push_timeout", {63'b0, req_ready}, 64'd1);
         req_valid = 1'b0;
      end else begin
         model(s, d, l, dec, next_id);
         next_id++;
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while ((busy || rq.size() != 0 || wq.size() != 0) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_drain"}, {62'b0, busy, (rq.size() + wq.size()) != 0}, 64'd0);
   endtask

   task automatic purge(input int kid);
      burst_t tr[$];
      burst_t tw[$];
      foreach (rq[i]) if (rq[i].id != kid) tr.push_back(rq[i]);
      foreach (wq[i]) if (wq[i].id != kid) tw.push_back(wq[i]);
      rq = tr;
      wq = tw;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int       k, kid, cyc;
      logic [2:0] seen;
      logic [31:0] s, d;

      rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_len = '0;
      req_dec = 1'b0; r_ready = 1'b0; w_ready = 1'b0; kill = 1'b0; rand_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("reset_state", {58'b0, r_valid, w_valid, req_ready, busy, r_last, w_last}, 64'b001000);
      @(negedge clk) rst_n = 1'b1;

      // Coupled split with 1-cycle latency from push
      r_ready = 1'b1; w_ready = 1'b1;
      push(32'h06, 32'h00, 32'd20, 1'b0);
      @(negedge clk);
      chk("coupled_latency", {62'b0, r_valid, w_valid}, 64'b11);
      wait_idle("coupled");

      // Decoupled: reads complete while writes are held off
      w_ready = 1'b0;
      push(32'h06, 32'h00, 32'd20, 1'b1);
      repeat (6) @(negedge clk);
      chk("decoupled_reads_only", {31'b0, w_valid, 16'(rq.size()), 16'(wq.size())},
          {31'b0, 1'b1, 16'd0, 16'd2});
      w_ready = 1'b1;
      wait_idle("decoupled");

      // Queue: fill the FIFO behind a stalled transfer, then drain with no bubbles
      r_ready = 1'b0; w_ready = 1'b0;
      push(32'h100, 32'h200, 32'd4, 1'b0);
      push(32'h110, 32'h210, 32'd4, 1'b0);
      push(32'h120, 32'h220, 32'd4, 1'b0);
      @(negedge clk);
      chk("queue_full_stall", {61'b0, req_ready, busy, r_valid}, 64'b011);
      seen = '0;
      fork
         push(32'h130, 32'h230, 32'd4, 1'b0);
         begin
            r_ready = 1'b1; w_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               seen[i] = r_valid & w_valid;
            end
         end
      join
      chk("queue_back_to_back", {61'b0, seen}, 64'b111);
      wait_idle("queue");

      // Kill during the 2nd burst of a 64-byte transfer; next request follows at once
      kid = next_id;
      push(32'h000, 32'h400, 32'd64, 1'b0);
      push(32'h040, 32'h500, 32'd8, 1'b0);
      k = 0;
      while (!(r_valid && r_addr == 32'h10) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("kill_reach_burst2", {31'b0, r_valid, r_addr}, {31'b0, 1'b1, 32'h10});
      kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      purge(kid);
      @(negedge clk);
      chk("kill_next_request", {30'b0, r_valid, w_valid, r_addr}, {30'b0, 2'b11, 32'h40});
      wait_idle("kill");

      // Zero-length transfer is a single one-beat burst
      push(32'h03, 32'h40, 32'd0, 1'b0);
      wait_idle("zero_len");

      // Asynchronous reset mid-transfer
      r_ready = 1'b0; w_ready = 1'b0;
      push(32'h000, 32'h000, 32'd64, 1'b0);
      push(32'h100, 32'h100, 32'd8, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_mid_transfer", {60'b0, r_valid, w_valid, req_ready, busy}, 64'b0010);
      rq.delete();
      wq.delete();
      @(negedge clk) rst_n = 1'b1;

      // Randomized requests against the model with random backpressure
      cyc = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               s = $urandom_range(0, 511);
               d = $urandom_range(0, 511);
               if ($urandom_range(0, 7) == 0) s = 32'hFFFF_FFC0 + $urandom_range(0, 63);
               if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFC0 + $urandom_range(0, 63);
               push(s, d, $urandom_range(0, 70), 1'($urandom_range(0, 1)));
            end
            rand_done = 1'b1;
         end
         begin
            while ((!rand_done || busy || rq.size() != 0 || wq.size() != 0) && cyc < 8000) begin
               @(posedge clk);
               #1;
               r_ready = 1'($urandom_range(0, 1));
               w_ready = 1'($urandom_range(0, 1));
               cyc++;
            end
            r_ready = 1'b1;
            w_ready = 1'b1;
         end
      join
      wait_idle("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
